// File: rtl/aor3000_store_buffer_pkg.sv
// Shared entry layout for the MEM-stage store buffer: field offsets inside the packed
// {write, mask, addr, data} word, so producer and consumer slice it identically.
package aor3000_store_buffer_pkg;

  function automatic int sb_data_lsb();
    return 0;
  endfunction

  function automatic int sb_addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int sb_mask_lsb(input int addr_w, input int data_w);
    return data_w + addr_w;
  endfunction

  function automatic int sb_write_bit(input int addr_w, input int data_w);
    return data_w + addr_w + data_w / 8;
  endfunction

  function automatic int sb_entry_w(input int addr_w, input int data_w);
    return 1 + data_w / 8 + addr_w + data_w;
  endfunction

  // Number of byte-offset address bits below the word address.
  function automatic int sb_off_w(input int mask_w);
    return (mask_w > 1) ? $clog2(mask_w) : 0;
  endfunction

endpackage

// File: rtl/aor3000_sb_match.sv
// One buffer entry versus the load being checked: a valid store to the same word
// with at least one overlapping byte enable.
module aor3000_sb_match
  import aor3000_store_buffer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MASK_W = 4
) (
  input  logic              entry_valid,
  input  logic              entry_write,
  input  logic [MASK_W-1:0] entry_mask,
  input  logic [ADDR_W-1:0] entry_addr,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [MASK_W-1:0] chk_mask,
  output logic              hit
);

  localparam int OFF_W = sb_off_w(MASK_W);

  logic word_eq;

  assign word_eq = (entry_addr >> OFF_W) == (chk_addr >> OFF_W);
  assign hit     = entry_valid && entry_write && word_eq && ((entry_mask & chk_mask) != '0);

endmodule

// File: rtl/aor3000_store_buffer.sv
// Circular external-access buffer between the MEM stage and the bus controller, with
// optional byte-merging of stores into the tail entry and load-conflict detection.
module aor3000_store_buffer
  import aor3000_store_buffer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MASK_W   = DATA_W / 8,
  parameter int MERGE_EN = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push_valid,
  output logic                             push_ready,
  input  logic                             push_write,
  input  logic [MASK_W-1:0]                push_mask,
  input  logic [ADDR_W-1:0]                push_addr,
  input  logic [DATA_W-1:0]                push_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MASK_W+ADDR_W+DATA_W:0]    out_entry,
  input  logic [ADDR_W-1:0]                chk_addr,
  input  logic [MASK_W-1:0]                chk_mask,
  output logic                             load_conflict,
  output logic [$clog2(DEPTH+1)-1:0]       level,
  output logic                             empty
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int OFF_W  = sb_off_w(MASK_W);
  localparam int W_BIT  = sb_write_bit(ADDR_W, DATA_W);
  localparam int M_LSB  = sb_mask_lsb(ADDR_W, DATA_W);
  localparam int A_LSB  = sb_addr_lsb(DATA_W);
  localparam int D_LSB  = sb_data_lsb();
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic              wr_q   [DEPTH];
  logic [MASK_W-1:0] mask_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;

  logic [PTR_W-1:0]  rd_ptr, wr_ptr, tail_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              full, pop, tail_hit, merge_cand, merge_ok, push_fire;
  logic [DEPTH-1:0]  hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign tail_ptr = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign out_valid = !empty;
  assign pop      = out_valid && out_ready;

  assign tail_hit   = (addr_q[tail_ptr] >> OFF_W) == (push_addr >> OFF_W);
  assign merge_cand = (MERGE_EN != 0) && push_valid && push_write && !empty
                      && wr_q[tail_ptr] && tail_hit;
  // A lone entry that is popping cannot absorb the store; it becomes a fresh push.
  assign merge_ok   = merge_cand && !(pop && level_q == LVL_W'(1));
  assign push_fire  = push_valid && !full && !merge_ok;
  // The pop qualifier only matters at level 1, which is never full, so push_ready
  // stays independent of out_ready.
  assign push_ready = merge_cand || !full;

  assign out_entry[W_BIT]             = wr_q[rd_ptr];
  assign out_entry[M_LSB +: MASK_W]   = mask_q[rd_ptr];
  assign out_entry[A_LSB +: ADDR_W]   = addr_q[rd_ptr];
  assign out_entry[D_LSB +: DATA_W]   = data_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
      vld_q   <= '0;
    end else begin
      if (pop) begin
        rd_ptr        <= ptr_inc(rd_ptr);
        vld_q[rd_ptr] <= 1'b0;
      end
      if (push_fire) begin
        wr_ptr        <= ptr_inc(wr_ptr);
        vld_q[wr_ptr] <= 1'b1;
      end
      case ({push_fire, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      wr_q[wr_ptr]   <= push_write;
      mask_q[wr_ptr] <= push_mask;
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end else if (merge_ok) begin
      mask_q[tail_ptr] <= mask_q[tail_ptr] | push_mask;
      for (int b = 0; b < MASK_W; b++) begin
        if (push_mask[b]) data_q[tail_ptr][8*b +: 8] <= push_data[8*b +: 8];
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    aor3000_sb_match #(
      .ADDR_W (ADDR_W),
      .MASK_W (MASK_W)
    ) u_match (
      .entry_valid (vld_q[i]),
      .entry_write (wr_q[i]),
      .entry_mask  (mask_q[i]),
      .entry_addr  (addr_q[i]),
      .chk_addr    (chk_addr),
      .chk_mask    (chk_mask),
      .hit         (hit[i])
    );
  end

  assign load_conflict = |hit;

endmodule

// File: tb/tb_aor3000_store_buffer.sv
// Directed bench for aor3000_store_buffer (DEPTH=4, DATA_W=32), plus a MERGE_EN=0
// instance sharing the same stimulus.
module tb_aor3000_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid, push_write, out_ready;
  logic [3:0]  push_mask, chk_mask;
  logic [31:0] push_addr, push_data, chk_addr;

  logic        push_ready, out_valid, load_conflict, empty;
  logic [68:0] out_entry;
  logic [2:0]  level;

  logic        nm_push_ready, nm_out_valid, nm_load_conflict, nm_empty;
  logic [68:0] nm_out_entry;
  logic [2:0]  nm_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aor3000_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .MERGE_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready), .push_write(push_write),
    .push_mask(push_mask), .push_addr(push_addr), .push_data(push_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
    .chk_addr(chk_addr), .chk_mask(chk_mask), .load_conflict(load_conflict),
    .level(level), .empty(empty)
  );

  aor3000_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .MERGE_EN(0)) u_nm (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(nm_push_ready), .push_write(push_write),
    .push_mask(push_mask), .push_addr(push_addr), .push_data(push_data),
    .out_valid(nm_out_valid), .out_ready(out_ready), .out_entry(nm_out_entry),
    .chk_addr(chk_addr), .chk_mask(chk_mask), .load_conflict(nm_load_conflict),
    .level(nm_level), .empty(nm_empty)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0; push_write = 1'b0; push_mask = '0;
    push_addr  = '0;   push_data  = '0;   out_ready = 1'b0;
    chk_addr   = '0;   chk_mask   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drive_push(input logic wr, input logic [3:0] m, input logic [31:0] a,
                            input logic [31:0] d);
    push_valid = 1'b1; push_write = wr; push_mask = m; push_addr = a; push_data = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b want 1", push_ready); end
    checks++; if (load_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b want 0", load_conflict); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b1, 4'hF, 32'h100 + 32'(4*i), 32'hA0 + 32'(i));
      step();
    end
    drive_push(1'b1, 4'hF, 32'h200, 32'hA4);
    #1;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d want 4", level); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fill_push_ready got %b want 0", push_ready); end
    out_ready = 1'b1;
    #1;
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_pop_push_ready got %b want 0", push_ready); end
    checks++; if (out_entry[63:32] !== 32'h100) begin errors++; $display("FAIL drain_head0 got %h want 00000100", out_entry[63:32]); end
    step();
    push_valid = 1'b0;
    #1;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL drain_level3 got %0d want 3", level); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (out_entry[63:32] !== 32'h100 + 32'(4*i)) begin
        errors++; $display("FAIL drain_head%0d got %h want %h", i, out_entry[63:32], 32'h100 + 32'(4*i));
      end
      checks++;
      if (out_entry[31:0] !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL drain_data%0d got %h want %h", i, out_entry[31:0], 32'hA0 + 32'(i));
      end
      step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_merge();
    do_reset();
    drive_push(1'b1, 4'b0011, 32'h40, 32'h0000BEEF);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL merge_no_bypass got %b want 0", out_valid); end
    step();
    drive_push(1'b1, 4'b1100, 32'h42, 32'hDEAD0000);
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL merge_ready got %b want 1", push_ready); end
    step();
    push_valid = 1'b0;
    #1;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL merge_level got %0d want 1", level); end
    checks++;
    if (out_entry !== {1'b1, 4'b1111, 32'h40, 32'hDEADBEEF}) begin
      errors++; $display("FAIL merge_entry got %h want %h", out_entry, {1'b1, 4'b1111, 32'h40, 32'hDEADBEEF});
    end
  endtask

  task automatic test_no_merge();
    do_reset();
    drive_push(1'b1, 4'b0001, 32'h40, 32'h11);
    step();
    drive_push(1'b0, 4'b0001, 32'h40, 32'h0);
    step();
    push_valid = 1'b0;
    #1;
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL nomerge_load_level got %0d want 2", level); end

    do_reset();
    drive_push(1'b1, 4'b0001, 32'h40, 32'h11);
    step();
    drive_push(1'b1, 4'b0010, 32'h40, 32'h2200);
    step();
    push_valid = 1'b0;
    #1;
    checks++; if (nm_level !== 3'd2) begin errors++; $display("FAIL nomerge_disabled_level got %0d want 2", nm_level); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL merge_enabled_level got %0d want 1", level); end

    do_reset();
    drive_push(1'b1, 4'b0001, 32'h40, 32'h11);
    step();
    drive_push(1'b1, 4'b0010, 32'h40, 32'h2200);
    out_ready = 1'b1;
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL leaving_tail_ready got %b want 1", push_ready); end
    step();
    push_valid = 1'b0;
    out_ready  = 1'b0;
    #1;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL leaving_tail_level got %0d want 1", level); end
    checks++;
    if (out_entry !== {1'b1, 4'b0010, 32'h40, 32'h00002200}) begin
      errors++; $display("FAIL leaving_tail_entry got %h want %h", out_entry, {1'b1, 4'b0010, 32'h40, 32'h00002200});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive_push(1'b1, 4'hF, 32'h300, 32'h300);
    step();
    drive_push(1'b1, 4'hF, 32'h304, 32'h304);
    step();
    for (int k = 0; k < 10; k++) begin
      drive_push(1'b1, 4'hF, 32'h308 + 32'(4*k), 32'h308 + 32'(4*k));
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_entry[31:0] !== 32'h300 + 32'(4*k)) begin
        errors++; $display("FAIL wrap_head%0d got %h want %h", k, out_entry[31:0], 32'h300 + 32'(4*k));
      end
      step();
      checks++;
      if (level !== 3'd2) begin errors++; $display("FAIL wrap_level%0d got %0d want 2", k, level); end
    end
    push_valid = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic test_conflict();
    do_reset();
    drive_push(1'b1, 4'b0001, 32'h80, 32'h5A);
    step();
    push_valid = 1'b0;
    chk_addr = 32'h80; chk_mask = 4'b0001;
    #1;
    checks++; if (load_conflict !== 1'b1) begin errors++; $display("FAIL conflict_hit got %b want 1", load_conflict); end
    chk_mask = 4'b0010;
    #1;
    checks++; if (load_conflict !== 1'b0) begin errors++; $display("FAIL conflict_mask_miss got %b want 0", load_conflict); end
    chk_addr = 32'h84; chk_mask = 4'b0001;
    #1;
    checks++; if (load_conflict !== 1'b0) begin errors++; $display("FAIL conflict_addr_miss got %b want 0", load_conflict); end
    chk_addr = 32'h83;
    #1;
    checks++; if (load_conflict !== 1'b1) begin errors++; $display("FAIL conflict_same_word got %b want 1", load_conflict); end

    do_reset();
    drive_push(1'b0, 4'b0001, 32'h80, 32'h0);
    step();
    push_valid = 1'b0;
    chk_addr = 32'h80; chk_mask = 4'b0001;
    #1;
    checks++; if (load_conflict !== 1'b0) begin errors++; $display("FAIL conflict_load_entry got %b want 0", load_conflict); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 4'hF, 32'h600 + 32'(4*i), 32'(i));
      step();
    end
    push_valid = 1'b0;
    out_ready  = 1'b1;
    #1;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL midrst_pre_level got %0d want 3", level); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL midrst_level got %0d want 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b want 1", empty); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    drive_push(1'b1, 4'hF, 32'h700, 32'h77);
    step();
    push_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_after_valid got %b want 1", out_valid); end
    checks++; if (out_entry[63:32] !== 32'h700) begin errors++; $display("FAIL midrst_after_head got %h want 00000700", out_entry[63:32]); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL midrst_after_level got %0d want 1", level); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_merge();
    test_no_merge();
    test_wrap();
    test_conflict();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
